// File: rtl/uart_rx_if.sv
// Serial line and sequencer outputs between the RX synchronizer, the sequencer
// and the shift register / data buffer.
interface uart_rx_if;
  logic serial_in;
  logic shift_strobe;
  logic sample_bit;
  logic load_buffer;
  logic framing_error;
  logic parity_error;
  logic rx_busy;

  modport master (
    output serial_in,
    input  shift_strobe, sample_bit, load_buffer, framing_error, parity_error, rx_busy
  );

  modport slave (
    input  serial_in,
    output shift_strobe, sample_bit, load_buffer, framing_error, parity_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start-edge detect, bit timing, mid-bit sample strobes,
// stop-bit validation. Optional even-parity check enabled by RX_PARITY_EN.
module uart_rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic      clk,
  input logic      n_rst,
  uart_rx_if.slave rx
);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW   = $clog2(DATA_BITS + 3);

  typedef enum logic [2:0] {IDLE, START_CHK, RECV, PARITY, STOP_CHK} state_t;

  state_t          state, state_nxt;
  logic            prev;
  logic            armed;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic            strobe_q, strobe_nxt;
  logic            sbit_q, sbit_nxt;
  logic            load_q, load_nxt;
  logic            ferr_q, ferr_nxt;
  logic            busy_q;
  logic            wrap_c;
`ifdef RX_PARITY_EN
  logic            par_q, par_nxt;
  logic            perr_q, perr_nxt;
`endif

  assign wrap_c = (cnt == CW'(CLKS_PER_BIT));

  // State and datapath registers; prev/armed track the line in every state.
  // armed stays low after reset until the line is seen high, so a line held
  // low across reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      prev     <= 1'b1;
      armed    <= 1'b0;
      cnt      <= '0;
      bcnt     <= '0;
      strobe_q <= 1'b0;
      sbit_q   <= 1'b0;
      load_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      prev     <= rx.serial_in;
      armed    <= armed | rx.serial_in;
      cnt      <= cnt_nxt;
      bcnt     <= bcnt_nxt;
      strobe_q <= strobe_nxt;
      sbit_q   <= sbit_nxt;
      load_q   <= load_nxt;
      ferr_q   <= ferr_nxt;
      busy_q   <= (state_nxt != IDLE);
`ifdef RX_PARITY_EN
      par_q    <= par_nxt;
      perr_q   <= perr_nxt;
`endif
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bcnt_nxt   = bcnt;
    strobe_nxt = 1'b0;
    sbit_nxt   = sbit_q;
    load_nxt   = 1'b0;
    ferr_nxt   = ferr_q;
`ifdef RX_PARITY_EN
    par_nxt    = par_q;
    perr_nxt   = perr_q;
`endif
    case (state)
      IDLE: begin
        if (armed && prev && !rx.serial_in) begin
          state_nxt = START_CHK;
          cnt_nxt   = '0;
          bcnt_nxt  = '0;
          ferr_nxt  = 1'b0;
`ifdef RX_PARITY_EN
          par_nxt   = 1'b0;
          perr_nxt  = 1'b0;
`endif
        end
      end
      START_CHK: begin
        // Mid-start-bit check; counter restarts at 1 so later samples land on wrap.
        if (cnt == CW'(HALF - 1)) begin
          if (rx.serial_in) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RECV;
            cnt_nxt   = CW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RECV: begin
        if (wrap_c) begin
          cnt_nxt    = CW'(1);
          strobe_nxt = 1'b1;
          sbit_nxt   = rx.serial_in;
          bcnt_nxt   = bcnt + BW'(1);
`ifdef RX_PARITY_EN
          par_nxt    = par_q ^ rx.serial_in;
          if (bcnt == BW'(DATA_BITS - 1)) state_nxt = PARITY;
`else
          if (bcnt == BW'(DATA_BITS - 1)) state_nxt = STOP_CHK;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (wrap_c) begin
          cnt_nxt   = CW'(1);
          bcnt_nxt  = bcnt + BW'(1);
          state_nxt = STOP_CHK;
          if (par_q ^ rx.serial_in) perr_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      STOP_CHK: begin
        if (wrap_c) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          bcnt_nxt  = '0;
          if (rx.serial_in) load_nxt = 1'b1;
          else              ferr_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        bcnt_nxt  = '0;
      end
    endcase
  end

  assign rx.shift_strobe  = strobe_q;
  assign rx.sample_bit    = sbit_q;
  assign rx.load_buffer   = load_q;
  assign rx.framing_error = ferr_q;
  assign rx.rx_busy       = busy_q;
`ifdef RX_PARITY_EN
  assign rx.parity_error  = perr_q;
`else
  assign rx.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: per-cycle line/reset schedule, frame-level
// expectation model, per-cycle compare plus literal timing pins.
module tb_uart_rx_sequencer;
  localparam int C    = 10;
  localparam int DB   = 8;
  localparam int HALF = C / 2;
`ifdef RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL   = (DB + 2 + P) * C;
  localparam int MAXN = 2000;

  logic clk;
  logic n_rst;
  uart_rx_if rx ();

  uart_rx_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .rx   (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus: value seen by the DUT at rising edge n.
  logic line [MAXN];
  logic rstv [MAXN];
  // Expected and observed outputs after edge n.
  logic e_stb [MAXN], e_sb [MAXN], e_ld [MAXN], e_fe [MAXN], e_pe [MAXN], e_bz [MAXN];
  logic g_stb [MAXN], g_sb [MAXN], g_ld [MAXN], g_fe [MAXN], g_pe [MAXN], g_bz [MAXN];

  int total = 0;
  int bad   = 0;
  int ncyc;
  int f1, gl, f3, f4, f5, f6, fp0, fp1, r0, f8;

  task automatic chk(input string name, input int cyc, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc, got, exp);
    end
  endtask

  // Lay a whole frame on the line; the falling start edge is seen at edge s.
  task automatic put_frame(input int s, input logic [15:0] data, input logic stop_v,
                           input logic par_v);
    for (int i = 0; i < C; i++) begin
      line[s + i] = 1'b0;
      for (int k = 0; k < DB; k++) line[s + (k + 1) * C + i] = data[k];
      if (P == 1) line[s + (DB + 1) * C + i] = par_v;
      line[s + (DB + 1 + P) * C + i] = stop_v;
    end
  endtask

  // Frame-level model: a frame is a start time e0; everything else is an
  // offset from it (HALF for the start check, HALF + j*C for bit j).
  task automatic run_model();
    bit in_frame = 0, armed = 0, prev = 1, par = 0;
    logic sb = 0, fe = 0, pe = 0;
    int e0 = 0;
    for (int n = 0; n < ncyc; n++) begin
      logic stb = 0, ld = 0;
      if (!rstv[n]) begin
        in_frame = 0; armed = 0; prev = 1; sb = 0; fe = 0; pe = 0; par = 0;
      end else begin
        if (in_frame) begin
          int d = n - e0;
          if (d == HALF && line[n]) begin
            in_frame = 0;
          end else if (d > HALF && (d - HALF) % C == 0) begin
            int j = (d - HALF) / C - 1;
            if (j < DB) begin
              stb = 1; sb = line[n]; par = par ^ line[n];
            end else if (P == 1 && j == DB) begin
              pe = par ^ line[n];
            end else begin
              if (line[n]) ld = 1; else fe = 1;
              in_frame = 0;
            end
          end
        end else if (armed && prev && !line[n]) begin
          in_frame = 1; e0 = n; fe = 0; pe = 0; par = 0;
        end
        armed = armed | line[n];
        prev  = line[n];
      end
      e_stb[n] = stb; e_sb[n] = sb; e_ld[n] = ld; e_fe[n] = fe; e_pe[n] = pe;
      e_bz[n]  = in_frame;
    end
  endtask

  task automatic capture_and_compare(input int n);
    g_stb[n] = rx.shift_strobe; g_sb[n] = rx.sample_bit; g_ld[n] = rx.load_buffer;
    g_fe[n]  = rx.framing_error; g_pe[n] = rx.parity_error; g_bz[n] = rx.rx_busy;
    chk("shift_strobe", n, g_stb[n], e_stb[n]);
    chk("sample_bit", n, g_sb[n], e_sb[n]);
    chk("load_buffer", n, g_ld[n], e_ld[n]);
    chk("framing_error", n, g_fe[n], e_fe[n]);
    chk("parity_error", n, g_pe[n], e_pe[n]);
    chk("rx_busy", n, g_bz[n], e_bz[n]);
  endtask

  initial begin
    int cur;
    logic [7:0] a5;
    n_rst = 1'b0;
    rx.serial_in = 1'b1;
    for (int n = 0; n < MAXN; n++) begin line[n] = 1'b1; rstv[n] = 1'b1; end
    for (int n = 0; n < 5; n++) rstv[n] = 1'b0;

    cur = 20;
    f1 = cur;  put_frame(f1, 16'hA5, 1'b1, 1'b0); cur += FL + 15;
    gl = cur;  for (int i = 0; i < 3; i++) line[gl + i] = 1'b0; cur += 30;
    f3 = cur;  put_frame(f3, 16'h3C, 1'b0, 1'b0); cur += FL + 10;
    f4 = cur;  put_frame(f4, 16'h81, 1'b1, 1'b0); cur += FL + 10;
    f5 = cur;  put_frame(f5, 16'h0F, 1'b1, 1'b0); cur += FL;
    f6 = cur;  put_frame(f6, 16'hF0, 1'b1, 1'b0); cur += FL + 20;
    fp0 = cur; put_frame(fp0, 16'h07, 1'b1, 1'b0); cur += FL + 10;
    fp1 = cur; put_frame(fp1, 16'h07, 1'b1, 1'b1); cur += FL + 10;
    r0 = cur;
    for (int i = 0; i <= 80; i++) line[r0 + i] = 1'b0;
    for (int i = 40; i < 43; i++) rstv[r0 + i] = 1'b0;
    f8 = r0 + 100; put_frame(f8, 16'h5A, 1'b1, 1'b0);
    ncyc = f8 + FL + 20;

    run_model();

    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (n > 0) capture_and_compare(n - 1);
      rx.serial_in = line[n];
      n_rst = rstv[n];
    end
    @(negedge clk);
    capture_and_compare(ncyc - 1);

    // Literal timing pins from hand calculation (HALF=5, C=10).
    a5 = 8'hA5;
    chk("pin reset busy", 4, g_bz[4], 1'b0);
    chk("pin busy before start", f1 - 1, g_bz[f1 - 1], 1'b0);
    chk("pin busy at start", f1, g_bz[f1], 1'b1);
    chk("pin no early strobe", f1 + 14, g_stb[f1 + 14], 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("pin strobe", f1 + 15 + 10 * k, g_stb[f1 + 15 + 10 * k], 1'b1);
      chk("pin sample_bit", f1 + 15 + 10 * k, g_sb[f1 + 15 + 10 * k], a5[k]);
      chk("model sample_bit", f1 + 15 + 10 * k, e_sb[f1 + 15 + 10 * k], a5[k]);
    end
    chk("pin strobe one cycle", f1 + 16, g_stb[f1 + 16], 1'b0);
    chk("pin load", f1 + 95 + 10 * P, g_ld[f1 + 95 + 10 * P], 1'b1);
    chk("model load", f1 + 95 + 10 * P, e_ld[f1 + 95 + 10 * P], 1'b1);
    chk("pin busy after stop", f1 + 95 + 10 * P, g_bz[f1 + 95 + 10 * P], 1'b0);
    chk("pin busy last", f1 + 94 + 10 * P, g_bz[f1 + 94 + 10 * P], 1'b1);
    for (int i = 0; i < 5; i++) chk("pin glitch busy", gl + i, g_bz[gl + i], 1'b1);
    chk("pin glitch idle", gl + 5, g_bz[gl + 5], 1'b0);
    chk("pin ferr pre", f3 + 94 + 10 * P, g_fe[f3 + 94 + 10 * P], 1'b0);
    chk("pin ferr set", f3 + 95 + 10 * P, g_fe[f3 + 95 + 10 * P], 1'b1);
    chk("pin ferr no load", f3 + 95 + 10 * P, g_ld[f3 + 95 + 10 * P], 1'b0);
    chk("pin ferr held", f4 - 1, g_fe[f4 - 1], 1'b1);
    chk("pin ferr clear", f4, g_fe[f4], 1'b0);
    chk("pin b2b strobe", f5 + 115 + 10 * P, g_stb[f5 + 115 + 10 * P], 1'b1);
    chk("pin b2b load2", f6 + 95 + 10 * P, g_ld[f6 + 95 + 10 * P], 1'b1);
    chk("pin reset busy0", r0 + 40, g_bz[r0 + 40], 1'b0);
    chk("pin held low no start", r0 + 60, g_bz[r0 + 60], 1'b0);
    chk("pin restart", f8, g_bz[f8], 1'b1);
`ifdef RX_PARITY_EN
    chk("pin perr set", fp0 + 95, g_pe[fp0 + 95], 1'b1);
    chk("pin perr pre", fp0 + 94, g_pe[fp0 + 94], 1'b0);
    chk("pin perr load", fp0 + 105, g_ld[fp0 + 105], 1'b1);
    chk("pin perr good", fp1 + 95, g_pe[fp1 + 95], 1'b0);
    chk("model perr", fp0 + 95, e_pe[fp0 + 95], 1'b1);
`else
    chk("pin perr tied", fp0 + 95, g_pe[fp0 + 95], 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
